alu_md_sequencer: RTL and testbench

Execute-stage operation controller that succeeds the combinational ALU-operation decoder. It decodes ALUOp/Funct7/Funct3 into the 4-bit ALU operation code for single-cycle integer ops. It also fully decodes the RV32M/RV64M multiply/divide group and executes those ops iteratively on a parametrised datapath. While a multi-cycle op is in flight it stalls the pipeline and returns a registered result with a one-cycle valid pulse.

---
 rtl/alu_ctrl_pkg.sv | 46 ++++
 rtl/md_iter_core.sv | 98 +++++++++
 rtl/alu_md_sequencer.sv | 152 +++++++++++++++
 tb/tb_alu_md_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and encodings for the execute-stage ALU / multiply-divide controller.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND    = 4'b0000,
    ALU_OR     = 4'b0001,
    ALU_ADD    = 4'b0010,
    ALU_XOR    = 4'b0011,
    ALU_SLL    = 4'b0100,
    ALU_SRL    = 4'b0101,
    ALU_SUB    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_SLT    = 4'b1000,
    ALU_SLTU   = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_op_e;

  // Values follow Funct3 of the M-extension encodings.
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} md_state_e;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_JUMP   = 2'b11;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_M    = 7'b0000001;

  function automatic logic md_is_div(md_op_e op);
    return op[2];
  endfunction

  function automatic logic md_a_signed(md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_b_signed(md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative radix-2 multiply / restoring-divide datapath working on operand magnitudes.
module md_iter_core
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            last,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN - 1);

  md_op_e              op_in;
  md_op_e              op_q;
  logic [2*XLEN-1:0]   acc;
  logic [2*XLEN-1:0]   acc_next;
  logic [XLEN-1:0]     divisor;
  logic [CW-1:0]       count;
  logic                q_neg;
  logic                r_neg;
  logic                a_neg;
  logic                b_neg;
  logic [XLEN:0]       sum;
  logic [XLEN:0]       rem_sh;
  logic [XLEN:0]       diff;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo;
  logic [XLEN-1:0]     rem;

  assign op_in = md_op_e'(op);
  assign a_neg = md_a_signed(op_in) & src_a[XLEN-1];
  assign b_neg = md_b_signed(op_in) & src_b[XLEN-1];
  assign last  = (count == '0);

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    sum      = '0;
    rem_sh   = '0;
    diff     = '0;
    acc_next = acc;
    if (md_is_div(op_q)) begin
      rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      diff   = rem_sh - {1'b0, divisor};
      if (!diff[XLEN]) acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else             acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, divisor} : '0);
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

  // Sign correction of the value the final step produces.
  always_comb begin
    prod_fix = q_neg ? -acc_next : acc_next;
    quo      = acc_next[XLEN-1:0];
    rem      = acc_next[2*XLEN-1:XLEN];
    result   = '0;
    case (op_q)
      MD_MUL:                       result = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result = q_neg ? -quo : quo;
      MD_REM, MD_REMU:              result = r_neg ? -rem : rem;
    endcase
  end

  // NOTE: state uses non-blocking assignments; the few datapath registers are reset as
  // well (cheap, and keeps the counter at 0 out of reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= MD_MUL;
      acc     <= '0;
      divisor <= '0;
      count   <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else if (start) begin
      op_q    <= op_in;
      acc     <= {{XLEN{1'b0}}, a_neg ? -src_a : src_a};
      divisor <= b_neg ? -src_b : src_b;
      count   <= CNT_INIT;
      q_neg   <= a_neg ^ b_neg;
      r_neg   <= a_neg;
    end else if (step) begin
      acc   <= acc_next;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/alu_md_sequencer.sv
// Execute-stage controller: ALU op decode plus a sequencer that runs M-extension ops
// on md_iter_core, stalling the pipeline until a registered result is ready.
module alu_md_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            is_imm,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic [3:0]      Operation,
  output logic            illegal,
  output logic            stall,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result
);

  md_state_e       state;
  md_state_e       state_next;
  alu_op_e         alu_op;
  logic            m_enc;
  logic            m_op;
  logic            is_shift;
  logic            bad_f7;
  logic            accept;
  logic            special;
  logic            ovf;
  logic            start;
  logic            step;
  logic            finish;
  logic            take_special;
  logic            core_last;
  logic [XLEN-1:0] core_result;
  logic [XLEN-1:0] special_res;

  assign m_enc    = (ALUOp == ALUOP_RTYPE) && !is_imm && (Funct7 == FUNCT7_M);
  assign m_op     = m_enc && EN_M;
  assign is_shift = (Funct3 == 3'b001) || (Funct3 == 3'b101);
  assign bad_f7   = is_imm ? (is_shift && Funct7 != FUNCT7_BASE && Funct7 != FUNCT7_ALT)
                           : !(Funct7 == FUNCT7_BASE ||
                               (Funct7 == FUNCT7_ALT && (Funct3 == 3'b000 || Funct3 == 3'b101)));

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (ALUOp)
      ALUOP_MEM:    alu_op = ALU_ADD;
      ALUOP_BRANCH: alu_op = ALU_SUB;
      ALUOP_JUMP:   alu_op = ALU_PASS_B;
      default: begin
        if (m_enc) begin
          illegal = !EN_M;
        end else if (bad_f7) begin
          illegal = 1'b1;
        end else begin
          case (Funct3)
            3'b000: alu_op = (!is_imm && Funct7 == FUNCT7_ALT) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            3'b101: alu_op = (Funct7 == FUNCT7_ALT) ? ALU_SRA : ALU_SRL;
            3'b110: alu_op = ALU_OR;
            default: alu_op = ALU_AND;
          endcase
        end
      end
    endcase
  end

  assign Operation = alu_op;

  // Divide by zero and signed overflow finish without iterating.
  assign ovf     = Funct3[2] && !Funct3[0] &&
                   (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (&src_b);
  assign special = Funct3[2] && ((src_b == '0) || ovf);

  always_comb begin
    if (Funct3[1]) special_res = (src_b == '0) ? src_a : '0;
    else           special_res = (src_b == '0) ? '1 : src_a;
  end

  assign accept = (state == ST_IDLE) && in_valid && m_op && !flush;
  assign stall  = accept || (state == ST_CALC);

  always_comb begin
    state_next   = state;
    start        = 1'b0;
    step         = 1'b0;
    finish       = 1'b0;
    take_special = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (special) begin
            state_next   = ST_DONE;
            take_special = 1'b1;
          end else begin
            state_next = ST_CALC;
            start      = 1'b1;
          end
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else begin
          step = 1'b1;
          if (core_last) begin
            state_next = ST_DONE;
            finish     = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      md_valid  <= 1'b0;
      md_result <= '0;
    end else begin
      state    <= state_next;
      md_valid <= take_special || finish;
      if (take_special) md_result <= special_res;
      else if (finish)  md_result <= core_result;
    end
  end

  md_iter_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .step   (step),
    .op     (Funct3),
    .src_a  (src_a),
    .src_b  (src_b),
    .last   (core_last),
    .result (core_result)
  );

endmodule

// File: tb/tb_alu_md_sequencer.sv
// Directed bench for alu_md_sequencer (XLEN=32) with an arithmetic reference model
// checked every cycle, plus an EN_M=0 instance sharing the same stimulus.
module tb_alu_md_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  ALUOp;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic        is_imm;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;

  logic [3:0]  Operation, op_x;
  logic        illegal, illegal_x;
  logic        stall, stall_x;
  logic        md_valid, md_valid_x;
  logic [31:0] md_result, md_result_x;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_md_sequencer #(.XLEN(32), .EN_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ALUOp(ALUOp), .Funct7(Funct7),
    .Funct3(Funct3), .is_imm(is_imm), .src_a(src_a), .src_b(src_b), .flush(flush),
    .Operation(Operation), .illegal(illegal), .stall(stall), .md_valid(md_valid),
    .md_result(md_result)
  );

  alu_md_sequencer #(.XLEN(32), .EN_M(1'b0)) dut_x (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ALUOp(ALUOp), .Funct7(Funct7),
    .Funct3(Funct3), .is_imm(is_imm), .src_a(src_a), .src_b(src_b), .flush(flush),
    .Operation(op_x), .illegal(illegal_x), .stall(stall_x), .md_valid(md_valid_x),
    .md_result(md_result_x)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam logic [31:0] BASE_OPS = {4'b0000, 4'b0001, 4'b0101, 4'b0011,
                                      4'b1001, 4'b1000, 4'b0100, 4'b0010};

  function automatic logic [4:0] exp_decode(input logic [1:0] aop, input logic [6:0] f7,
                                            input logic [2:0] f3, input logic imm,
                                            input bit en_m);
    logic [31:0] tbl;
    logic [3:0]  op;
    bit          legal;
    tbl = BASE_OPS;
    if (aop == 2'b00) return {1'b0, 4'b0010};
    if (aop == 2'b01) return {1'b0, 4'b0110};
    if (aop == 2'b11) return {1'b0, 4'b1010};
    if (!imm && f7 == 7'h01) return {!en_m, 4'b0010};
    if (imm) legal = !(f3 == 3'd1 || f3 == 3'd5) || f7 == 7'h00 || f7 == 7'h20;
    else     legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    if (!legal) return {1'b1, 4'b0010};
    op = tbl[f3*4 +: 4];
    if (f7 == 7'h20 && f3 == 3'd5) op = 4'b0111;
    if (f7 == 7'h20 && f3 == 3'd0 && !imm) op = 4'b0110;
    return {1'b0, op};
  endfunction

  function automatic bit ref_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  int          m_left;
  bit          m_done;
  logic [31:0] m_res;
  logic [31:0] m_pend;

  function automatic bit m_in();
    return ALUOp == 2'b10 && !is_imm && Funct7 == 7'h01;
  endfunction

  // Cycle-level model: an accepted op occupies XLEN cycles, then one result cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 0;
      m_res  = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      if (flush) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          m_res  = m_pend;
        end
      end
    end else if (in_valid && m_in() && !flush) begin
      m_pend = ref_md(Funct3, src_a, src_b);
      if (ref_special(Funct3, src_a, src_b)) begin
        m_done = 1;
        m_res  = m_pend;
      end else m_left = 32;
    end
  end

  always @(negedge clk) begin
    logic [4:0] e1, e0;
    if (rst_n) begin
      e1 = exp_decode(ALUOp, Funct7, Funct3, is_imm, 1'b1);
      e0 = exp_decode(ALUOp, Funct7, Funct3, is_imm, 1'b0);
      check("cyc_operation", Operation, e1[3:0]);
      check("cyc_illegal", illegal, e1[4]);
      check("cyc_operation_x", op_x, e0[3:0]);
      check("cyc_illegal_x", illegal_x, e0[4]);
      check("cyc_stall", stall,
            (m_left == 0 && !m_done && in_valid && m_in() && !flush) || m_left > 0);
      check("cyc_md_valid", md_valid, m_done);
      check("cyc_md_result", md_result, m_res);
      check("cyc_stall_x", stall_x, 1'b0);
      check("cyc_md_valid_x", md_valid_x, 1'b0);
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic [1:0] aop;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       imm;
    logic [3:0] op;
    logic       ill;
  } dvec_t;

  dvec_t dv [10] = '{
    '{2'b10, 7'h20, 3'b101, 1'b0, 4'b0111, 1'b0},
    '{2'b10, 7'h00, 3'b101, 1'b0, 4'b0101, 1'b0},
    '{2'b10, 7'h18, 3'b101, 1'b0, 4'b0010, 1'b1},
    '{2'b10, 7'h20, 3'b000, 1'b0, 4'b0110, 1'b0},
    '{2'b10, 7'h20, 3'b000, 1'b1, 4'b0010, 1'b0},
    '{2'b10, 7'h55, 3'b010, 1'b1, 4'b1000, 1'b0},
    '{2'b00, 7'h00, 3'b111, 1'b0, 4'b0010, 1'b0},
    '{2'b01, 7'h00, 3'b000, 1'b0, 4'b0110, 1'b0},
    '{2'b11, 7'h00, 3'b000, 1'b0, 4'b1010, 1'b0},
    '{2'b10, 7'h01, 3'b000, 1'b0, 4'b0010, 1'b0}
  };

  logic first_ill_x, first_stall_x;

  task automatic run_mop(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_cyc);
    int cyc, stalls;
    bit got;
    logic [31:0] res;
    ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = f3; is_imm = 1'b0;
    src_a = a; src_b = b; in_valid = 1'b1;
    cyc = 0; stalls = 0; got = 0; res = 'x;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (cyc == 0) begin
        first_ill_x   = illegal_x;
        first_stall_x = stall_x;
      end
      if (md_valid) begin
        got = 1;
        res = md_result;
      end else begin
        if (stall) stalls++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({nm, "_valid_cycle"}, cyc, exp_cyc);
    check({nm, "_stall_cycles"}, stalls, exp_cyc);
    check({nm, "_result"}, res, exp_res);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; ALUOp = 2'b00; Funct7 = 7'h00;
    Funct3 = 3'b000; is_imm = 1'b0; src_a = '0; src_b = '0;
    #3;
    check("reset_md_valid", md_valid, 1'b0);
    check("reset_md_result", md_result, 32'h0);
    check("reset_stall", stall, 1'b0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (dv[i]) begin
      ALUOp = dv[i].aop; Funct7 = dv[i].f7; Funct3 = dv[i].f3; is_imm = dv[i].imm;
      #1;
      check($sformatf("decode_op_%0d", i), Operation, dv[i].op);
      check($sformatf("decode_illegal_%0d", i), illegal, dv[i].ill);
    end
    @(posedge clk); #1;

    run_mop("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    check("enm0_mul_illegal", first_ill_x, 1'b1);
    check("enm0_mul_stall", first_stall_x, 1'b0);
    run_mop("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_mop("mulh", 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33);
    run_mop("mulhsu", 3'b010, 32'd2, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    run_mop("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_mop("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_mop("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_mop("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    run_mop("div_zero", 3'b100, 32'd55, 32'd0, 32'hFFFF_FFFF, 1);
    run_mop("remu_zero", 3'b111, 32'h1234, 32'd0, 32'h1234, 1);
    run_mop("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_mop("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // Flush in CALC cycle 10, then a DIVU issued in the very next cycle.
    ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'b101; is_imm = 1'b0;
    src_a = 32'd1000; src_b = 32'd3; in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_stall", stall, 1'b0);
    check("flush_md_valid", md_valid, 1'b0);
    run_mop("divu_after_flush", 3'b101, 32'd100, 32'd7, 32'd14, 33);

    // Asynchronous reset in the middle of CALC.
    ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'b000; src_a = 32'd3; src_b = 32'd5;
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check("midreset_stall", stall, 1'b0);
    check("midreset_md_valid", md_valid, 1'b0);
    check("midreset_md_result", md_result, 32'h0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_mop("div_after_reset", 3'b100, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
